// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: source select,
// arbiter FSM states and the LU result entry layout at default widths.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_LU = 1'b1
  } wport_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } lu_entry_t;

endpackage

// File: rtl/wb_wport_arbiter_if.sv
// Bus bundle between the pipeline (master) and the write-port arbiter (slave).
interface wb_wport_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_src;
  logic          stall_req;
  logic [31:0]   busy_mask;

  modport master (
    output wb_we, wb_waddr, wb_wdata, lu_valid, lu_addr, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, busy_mask
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, lu_valid, lu_addr, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, busy_mask
  );
endinterface

// File: rtl/lu_result_fifo.sv
// Circular buffer of LU results with a per-entry live bit, cancel-by-address
// and head pop; also produces the registered busy mask of live destinations.
module lu_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          cancel,
  input  logic [AW-1:0] cancel_addr,
  output logic [CW-1:0] count,
  output logic          head_live,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [31:0]   busy_mask
);

  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [31:0]      busy_d;

  assign head_live = live_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Busy mask is built from the post-edge view so it lands with the entry update.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cancel && addr_q[i] == cancel_addr) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr] = 1'b0;
    if (push) live_d[wr_ptr] = 1'b1;
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i])
        busy_d = busy_d | (32'd1 << ((push && wr_ptr == PW'(i)) ? push_addr : addr_q[i]));
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      busy_mask <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q    <= live_d;
      busy_mask <= busy_d;
      if (push) begin
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_wport_arbiter.sv
// Shares the register-file write port between WB (always first) and buffered
// LU results; requests a pipeline stall when the head result waits too long.
//   state | meaning
//   IDLE  | buffer empty
//   WAIT  | head buffered, counting cycles without a free slot
//   FORCE | head starved, stall_req held until the head pops
module wb_wport_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int DW       = 32,
  parameter int AW       = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_wport_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT) + 1;

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] count, count_d;
  logic          head_live;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [31:0]   busy_mask;
  logic          wb_write, lu_store, pop, lu_drain;
  logic          ready_q, stall_q, rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  wport_src_e    rf_src_q;

  assign wb_write = bus.wb_we && (bus.wb_waddr != '0);
  // r0 results and results overwritten by WB this same cycle are accepted but never stored.
  assign lu_store = bus.lu_valid && ready_q && (bus.lu_addr != '0)
                    && !(wb_write && bus.wb_waddr == bus.lu_addr);
  assign pop      = (count != '0) && (!head_live || !wb_write);
  assign lu_drain = pop && head_live;
  assign count_d  = count + CW'(lu_store) - CW'(pop);

  lu_result_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (lu_store),
    .push_addr   (bus.lu_addr),
    .push_data   (bus.lu_data),
    .pop         (pop),
    .cancel      (wb_write),
    .cancel_addr (bus.wb_waddr),
    .count       (count),
    .head_live   (head_live),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .busy_mask   (busy_mask)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (count_d != '0) state_d = WAIT;
      end
      WAIT: begin
        if (count_d == '0) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (pop) begin
          wait_d = '0;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WW'(MAX_WAIT - 1)) state_d = FORCE;
        end
      end
      FORCE: begin
        if (pop) begin
          wait_d  = '0;
          state_d = (count_d == '0) ? IDLE : WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      ready_q    <= 1'b1;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= SRC_WB;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= (count_d < CW'(DEPTH));
      stall_q <= (state_d == FORCE);
      rf_we_q <= wb_write || lu_drain;
      if (wb_write) begin
        rf_waddr_q <= bus.wb_waddr;
        rf_wdata_q <= bus.wb_wdata;
        rf_src_q   <= SRC_WB;
      end else if (lu_drain) begin
        rf_waddr_q <= head_addr;
        rf_wdata_q <= head_data;
        rf_src_q   <= SRC_LU;
      end else begin
        rf_waddr_q <= '0;
        rf_wdata_q <= '0;
        rf_src_q   <= SRC_WB;
      end
    end
  end

  assign bus.lu_ready  = ready_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rf_src    = (rf_src_q == SRC_LU);
  assign bus.stall_req = stall_q;
  assign bus.busy_mask = busy_mask;

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the arbiter.
module tb_wb_wport_arbiter;
  import wb_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int AW       = 5;
  localparam int DW       = 32;

  typedef struct {
    bit            full;
    logic          rf_we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          src;
    logic          stall;
    logic [31:0]   busy;
    logic          ready;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_wport_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t      exp_q[$];
  lu_entry_t model_q[$];
  int        age = 0;
  int        n_checks = 0;
  int        n_pass = 0;
  bit        mon_en = 1'b0;

  function automatic exp_t rst_exp();
    exp_t e;
    e.full = 1'b1; e.rf_we = 1'b0; e.waddr = '0; e.wdata = '0; e.src = 1'b0;
    e.stall = 1'b0; e.busy = '0; e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e = rst_exp();
    e.full = 1'b0;
    return e;
  endfunction

  task automatic drive_idle();
    bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
  endtask

  // One cycle: drive inputs, advance the model, queue the outputs due after the next edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    exp_t e;
    bit wbw, ready, nonempty, pop;
    @(posedge clk); #1;
    bus.wb_we = we; bus.wb_waddr = wa; bus.wb_wdata = wd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
    wbw      = we && (wa != '0);
    ready    = model_q.size() < DEPTH;
    nonempty = model_q.size() != 0;
    pop      = nonempty && (!model_q[0].live || !wbw);
    e = idle_exp();
    if (wbw) begin
      e.rf_we = 1'b1; e.waddr = wa; e.wdata = wd; e.src = 1'b0;
    end else if (pop && model_q[0].live) begin
      e.rf_we = 1'b1; e.waddr = model_q[0].addr; e.wdata = model_q[0].data; e.src = 1'b1;
    end
    if (wbw) foreach (model_q[i]) if (model_q[i].addr == wa) model_q[i].live = 1'b0;
    if (pop) void'(model_q.pop_front());
    if (lv && ready && la != '0 && !(wbw && la == wa))
      model_q.push_back('{live: 1'b1, addr: la, data: ld});
    if (!nonempty || pop) age = 0; else age++;
    e.stall = nonempty && !pop && (age >= MAX_WAIT);
    foreach (model_q[i]) if (model_q[i].live) e.busy[model_q[i].addr] = 1'b1;
    e.ready = model_q.size() < DEPTH;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset applied mid-cycle: outputs go to reset values immediately.
  task automatic enter_reset(input int hold);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive_idle();
    exp_q.delete();
    model_q.delete();
    age = 0;
    exp_q.push_back(rst_exp());
    for (int i = 0; i < hold; i++) begin
      exp_q.push_back(rst_exp());
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    exp_q.push_back(idle_exp());
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit ok;
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        ok = (bus.rf_we === e.rf_we) && (bus.stall_req === e.stall) &&
             (bus.busy_mask === e.busy) && (bus.lu_ready === e.ready);
        if (e.full || e.rf_we)
          ok = ok && (bus.rf_waddr === e.waddr) && (bus.rf_wdata === e.wdata) &&
               (bus.rf_src === e.src);
        if (ok) n_pass++;
        else
          $display("FAIL cycle_outputs at %0t: got we=%b a=%0d d=%h src=%b stall=%b busy=%h rdy=%b, want we=%b a=%0d d=%h src=%b stall=%b busy=%h rdy=%b",
                   $time, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src, bus.stall_req,
                   bus.busy_mask, bus.lu_ready, e.rf_we, e.waddr, e.wdata, e.src, e.stall,
                   e.busy, e.ready);
      end
    end
  end

  initial begin
    int mode;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    exp_q.push_back(rst_exp());
    reset_n = 1'b1;
    exp_q.push_back(idle_exp());

    // LU result into idle WB slots
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_00AA);
    idle(3);

    // WB busy long enough to force a stall, then a bubble
    step(1'b1, 5'd3, 32'h3333, 1'b1, 5'd7, 32'h7777);
    repeat (5) step(1'b1, 5'd3, 32'h3334, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    idle(3);

    // Fill the buffer, refused push, then one free slot
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd8, 32'h88);
    step(1'b1, 5'd3, 32'h2, 1'b1, 5'd9, 32'h99);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd11, 32'hBB);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 5'd3, 32'h4, 1'b0, '0, '0);
    idle(3);

    // WB overwrite cancels a buffered result
    step(1'b1, 5'd3, 32'h5, 1'b1, 5'd10, 32'hDEAD);
    step(1'b1, 5'd10, 32'h1234, 1'b0, '0, '0);
    idle(3);

    // r0 push and same-cycle WB collision are both discarded
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h66);
    idle(2);

    // Reset with two results buffered and stall_req raised
    step(1'b1, 5'd3, 32'h6, 1'b1, 5'd12, 32'hC);
    step(1'b1, 5'd3, 32'h7, 1'b1, 5'd13, 32'hD);
    repeat (6) step(1'b1, 5'd3, 32'h8, 1'b0, '0, '0);
    enter_reset(2);
    idle(2);

    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 599) == 0) begin
        enter_reset(1);
      end else begin
        step(($urandom_range(0, 99) < (mode == 0 ? 30 : (mode == 1 ? 60 : 95))),
             AW'($urandom_range(0, 7)), $urandom(),
             ($urandom_range(0, 99) < 50), AW'($urandom_range(0, 7)), $urandom());
      end
    end
    idle(4);
    @(negedge clk); #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_wport_arbiter.md
Name: wb_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage and a long-latency unit (LU: multiplier/divider) result stream.
- WB always has priority. LU results are buffered in a small FIFO and drained into idle WB slots.
- If an LU result waits too long, the block requests a pipeline stall to force a free slot.
- Exports a busy mask of pending destination registers for the hazard unit.

Parameters:
DEPTH, 2, LU result buffer entries (power of two, >=2)
MAX_WAIT, 4, cycles the head entry may wait before stall_req asserts (>=1)
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
wb_we  in  1  WB stage write enable (wb_reg_write_final)
wb_waddr  in  AW  WB destination register (wb_writereg)
wb_wdata  in  DW  WB write data (wb_wdata)
lu_valid  in  1  LU result valid
lu_addr  in  AW  LU destination register
lu_data  in  DW  LU result data
lu_ready  out  1  buffer can accept (registered: count < DEPTH)
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  AW  register-file write address (registered)
rf_wdata  out  DW  register-file write data (registered)
rf_src  out  1  0 = WB, 1 = LU for the current rf_* write
stall_req  out  1  freeze IF..MEM so a bubble reaches WB (registered)
busy_mask  out  32  bit r set when a live buffered entry targets r (registered)

Behaviour:
- Reset (reset_n low, asynchronous): buffer emptied; FSM to IDLE; wait counter 0. rf_we, rf_waddr, rf_wdata, rf_src, stall_req, busy_mask are 0. lu_ready is 1. Reset mid-operation discards all buffered results.
- WB slot free in cycle t: wb_we==0 or wb_waddr==0.
- WB write in cycle t with wb_waddr!=0: rf_we=1, rf_src=0, with the same addr/data at t+1 (one-cycle latency).
- LU handshake:
  - Push when lu_valid && lu_ready.
  - lu_addr==0: accepted and discarded.
  - Same-cycle WB write to the same addr: the LU entry is dropped (WB wins).
  - lu_ready reflects the count at the start of the cycle; no push at full, even if a pop occurs that cycle.
- Drain: in a cycle with a free WB slot and a live head entry, the head pops and appears on rf_* with rf_src=1 at the next edge.
  - Earliest LU write is t+2 for a push in cycle t.
  - No bypass from lu_* to rf_*.
- Cancellation: a WB write whose addr matches a live buffered entry marks that entry dead and clears its busy_mask bit at the next edge. A dead head pops in any cycle, WB busy or not, with no write.
- Push and pop in the same cycle are legal; the count updates by net 0.
- FSM:
  - IDLE: buffer empty. Go to WAIT on a push.
  - WAIT: wait_cnt increments each cycle the live head is not popped. It resets to 0 on each pop.
    - Buffer empties: go to IDLE.
    - wait_cnt == MAX_WAIT-1 with no pop: go to FORCE.
  - FORCE: stall_req=1 (registered; asserted the cycle after entry). Held until the head pops.
    - On pop with buffer empty: go to IDLE.
    - On pop with entries remaining: go to WAIT, wait_cnt=0.
    - stall_req deasserts the cycle after the pop.
- busy_mask: the OR of one-hot(addr) over live entries. Updated one edge after push, pop, or cancel. Bit 0 is always 0.
- Pointers wrap modulo DEPTH. The count has AW-independent width clog2(DEPTH)+1.

Decomposition:
- Shared package wb_pkg: typedef wport_src_e {SRC_WB, SRC_LU}; typedef arb_state_e {IDLE, WAIT, FORCE}; struct lu_entry_t {logic live; logic [AW-1:0] addr; logic [DW-1:0] data}.
- Sub-module lu_result_fifo: DEPTH-entry circular buffer with per-entry live bit, a cancel-by-address port, and head-pop. The arbiter FSM, wait counter, and output registers stay in wb_wport_arbiter.

Test Plan:
- Reset mid-stream with 2 entries buffered and stall_req=1 -> next cycle all outputs 0, lu_ready=1, busy_mask=0.
- WB idle; LU push r5=0x0000_00AA at t -> rf_we=1, rf_waddr=5, rf_wdata=0xAA, rf_src=1 at t+2. busy_mask bit 5 high only during t+1.
- WB writes r3 every cycle; LU push r7 at t with MAX_WAIT=4 -> stall_req rises at t+5. Drive wb_we=0 at t+6 -> r7 written at t+7, stall_req low at t+7.
- Fill buffer (r8, r9) with WB busy -> lu_ready=0. Free one slot -> r8 written, lu_ready returns 1 the cycle after the pop.
- Buffered r10 live; WB writes r10=0x1234 -> rf gets 0x1234 from WB, busy_mask[10] clears, and the LU r10 value is never written.
- LU push r0, and LU push r4 in the same cycle as WB writes r4 -> neither is buffered; count stays 0; only the WB write appears.
